event_accum: RTL and testbench
==============================

EVENT_ACCUM -- requirements
Module: event_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the pending-event counter.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_event  input  1  one-cycle source event; each high cycle is one event.
REQ-005 SHALL have port clr  input  1  synchronous clear of counter and overflow.
REQ-006 SHALL have port busy  input  1  busy from the downstream event-crossing stage.
REQ-007 SHALL have port out_event  output  1  registered one-cycle pulse to the downstream src_event.
REQ-008 SHALL have port pending  output  CNT_W  events accepted but not yet issued.
REQ-009 SHALL have port overflow  output  1  sticky flag: an event was dropped at saturation.
REQ-010 SHALL have port idle  output  1  high when pending==0 and FSM in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, ARM, DRAIN.
REQ-012 IDLE SHALL go to ISSUE when pending!=0 and busy==0; otherwise stay.
REQ-013 ISSUE SHALL last exactly one cycle with out_event=1, then go to ARM.
REQ-014 out_event SHALL be 0 in every state other than ISSUE.
REQ-015 ARM SHALL wait for busy==1, then go to DRAIN.
REQ-016 DRAIN SHALL wait for busy==0, then go to IDLE.
REQ-017 Issue rate SHALL therefore be at most one out_event per completed downstream busy cycle; never two out_event pulses without an intervening busy high-then-low.
REQ-018 pending SHALL decrement by 1 on the IDLE->ISSUE transition (the decrement cycle).
REQ-019 pending SHALL increment by 1 on each in_event cycle.
REQ-020 Simultaneous in_event and decrement SHALL leave pending unchanged.
REQ-021 in_event with pending at 2^CNT_W-1 and no decrement SHALL leave pending saturated and set overflow=1.
REQ-022 in_event with pending at max and a decrement in the same cycle SHALL leave pending at max without setting overflow.
REQ-023 pending SHALL never wrap: no increment past max, no decrement below 0.
REQ-024 clr SHALL set pending=0 and overflow=0 next cycle, dominating in_event and the decrement in that cycle.
REQ-025 clr SHALL NOT affect FSM state; an in-flight ISSUE/ARM/DRAIN handshake SHALL complete normally.
REQ-026 overflow SHALL stay 1 until clr or reset.
REQ-027 idle SHALL be combinational from pending and FSM state.
REQ-028 An event arriving while FSM is in ARM/DRAIN SHALL be counted and issued after DRAIN exits.

Reset
REQ-029 reset_n low SHALL asynchronously force state=IDLE, out_event=0, pending=0, overflow=0; idle=1.
REQ-030 Reset deassertion mid-handshake SHALL restart from IDLE with no out_event in the first cycle after release.

Verification
REQ-031 Single event: in_event pulse at cycle 0, busy high cycles 3-8 -> out_event high only at cycle 2, pending 1 at cycle 1 then 0 at cycle 2, idle=1 from cycle 9.
REQ-032 Burst: 3 back-to-back in_event, downstream model busy for 6 cycles per event -> exactly 3 out_event pulses, each after busy fell, pending 3->2->1->0.
REQ-033 Saturation: CNT_W=2, busy held high, 5 in_event -> pending=3, overflow=1; clr -> pending=0, overflow=0 next cycle.
REQ-034 Simultaneous: pending=2, in_event coincident with IDLE->ISSUE -> pending stays 2; at pending=3 (CNT_W=2) same case -> overflow stays 0.
REQ-035 clr mid-handshake: clr during ARM with pending=4 -> pending=0, FSM still passes DRAIN->IDLE, no further out_event.
REQ-036 Reset mid-DRAIN: assert reset_n low with pending=5 -> outputs reset immediately, no out_event after release until a new in_event.

Source files
------------

// File: rtl/event_accum.sv
// Event accumulator: counts one-cycle source events and issues them one at a time
// to a downstream stage, pacing each issue on a full busy high-then-low handshake.
module event_accum #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_event,
  input  logic             clr,
  input  logic             busy,
  output logic             out_event,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             idle
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   dec_c;

  // Issue handshake sequencing; dec_c marks the IDLE->ISSUE cycle
  always_comb begin
    state_next = state;
    dec_c      = 1'b0;
    case (state)
      IDLE: begin
        if ((pending != '0) && !busy) begin
          state_next = ISSUE;
          dec_c      = 1'b1;
        end
      end
      ISSUE: state_next = ARM;
      ARM: begin
        if (busy) state_next = DRAIN;
      end
      DRAIN: begin
        if (!busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_event <= 1'b0;
    end else begin
      state     <= state_next;
      out_event <= (state_next == ISSUE);
    end
  end

  // Saturating counter; clr wins over both increment and decrement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (in_event && !dec_c) begin
      if (pending == CNT_MAX) begin
        overflow <= 1'b1;
      end else begin
        pending <= pending + CNT_W'(1);
      end
    end else if (dec_c && !in_event) begin
      pending <= pending - CNT_W'(1);
    end
  end

  assign idle = (pending == '0) && (state == IDLE);

endmodule

// File: tb/tb_event_accum.sv
// Directed bench for event_accum: a wide (CNT_W=8) and a narrow (CNT_W=2) instance
// checked every cycle against an arithmetic handshake model plus literal expectations.
module tb_event_accum;

  localparam int unsigned WA = 8;
  localparam int unsigned WB = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          ev_a = 1'b0, clr_a = 1'b0, man_busy_a = 1'b0;
  logic          resp_busy = 1'b0, auto_mode = 1'b0;
  logic          busy_a;
  logic          ev_b = 1'b0, clr_b = 1'b0, busy_b = 1'b0;
  logic          out_a, ovf_a, idle_a;
  logic [WA-1:0] pend_a;
  logic          out_b, ovf_b, idle_b;
  logic [WB-1:0] pend_b;

  assign busy_a = auto_mode ? resp_busy : man_busy_a;

  event_accum #(.CNT_W(WA)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .in_event(ev_a), .clr(clr_a), .busy(busy_a),
    .out_event(out_a), .pending(pend_a), .overflow(ovf_a), .idle(idle_a)
  );

  event_accum #(.CNT_W(WB)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_event(ev_b), .clr(clr_b), .busy(busy_b),
    .out_event(out_b), .pending(pend_b), .overflow(ovf_b), .idle(idle_b)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;
  int out_cnt_a = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: count = count + events - issues, clamped at max (clamp => dropped event).
  // Handshake tokens: 0 free, 1 just issued, 2 awaiting busy rise, 3 awaiting busy fall.
  typedef struct {
    int pend;
    bit ovf;
    int ph;
    bit out;
  } mst_t;

  mst_t ma = '{0, 1'b0, 0, 1'b0};
  mst_t mb = '{0, 1'b0, 0, 1'b0};

  function automatic mst_t mstep(mst_t s, int maxv, bit ev, bit c, bit b);
    mst_t n;
    bit   go;
    n  = s;
    go = (s.ph == 0) && (s.pend > 0) && !b;
    case (s.ph)
      0: if (go) n.ph = 1;
      1: n.ph = 2;
      2: if (b) n.ph = 3;
      default: if (!b) n.ph = 0;
    endcase
    n.out = go;
    if (c) begin
      n.pend = 0;
      n.ovf  = 1'b0;
    end else begin
      n.pend = s.pend + int'(ev) - int'(go);
      if (n.pend > maxv) begin
        n.pend = maxv;
        n.ovf  = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma <= '{0, 1'b0, 0, 1'b0};
      mb <= '{0, 1'b0, 0, 1'b0};
    end else begin
      ma <= mstep(ma, 255, ev_a, clr_a, busy_a);
      mb <= mstep(mb, 3, ev_b, clr_b, busy_b);
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (out_a === 1'b1) out_cnt_a++;
    if (started) begin
      chk("a_pending",  64'(pend_a), 64'(ma.pend));
      chk("a_out",      64'(out_a),  64'(ma.out));
      chk("a_overflow", 64'(ovf_a),  64'(ma.ovf));
      chk("a_idle",     64'(idle_a), 64'((ma.pend == 0) && (ma.ph == 0)));
      chk("b_pending",  64'(pend_b), 64'(mb.pend));
      chk("b_out",      64'(out_b),  64'(mb.out));
      chk("b_overflow", 64'(ovf_b),  64'(mb.ovf));
      chk("b_idle",     64'(idle_b), 64'((mb.pend == 0) && (mb.ph == 0)));
    end
  end

  // Downstream responder: busy for 6 cycles starting the cycle after each pulse
  int resp_cnt = 0;
  always @(negedge clk) begin
    if (resp_cnt > 0) begin
      resp_busy = 1'b1;
      resp_cnt--;
    end else begin
      resp_busy = 1'b0;
    end
    if (out_a === 1'b1) resp_cnt = 6;
  end

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int waited;
    nc(3);
    chk("reset_pending", 64'(pend_a), 64'd0);
    chk("reset_idle",    64'(idle_a), 64'd1);
    reset_n = 1'b1;
    started = 1'b1;
    nc(2);

    // Single event: event at cycle 0, busy high cycles 3-8
    base = out_cnt_a;
    ev_a = 1'b1;
    nc(1); ev_a = 1'b0;
    chk("s1_pend_c1", 64'(pend_a), 64'd1);
    chk("s1_out_c1",  64'(out_a),  64'd0);
    nc(1);
    chk("s1_out_c2",  64'(out_a),  64'd1);
    chk("s1_pend_c2", 64'(pend_a), 64'd0);
    nc(1); man_busy_a = 1'b1;
    chk("s1_out_c3",  64'(out_a),  64'd0);
    nc(6); man_busy_a = 1'b0;
    nc(1);
    chk("s1_idle",    64'(idle_a), 64'd1);
    chk("s1_pulses",  64'(out_cnt_a - base), 64'd1);

    // Burst of 3 queued behind busy, then released to the responder
    man_busy_a = 1'b1;
    ev_a = 1'b1;
    nc(3); ev_a = 1'b0;
    chk("s2_pend3", 64'(pend_a), 64'd3);
    base = out_cnt_a;
    man_busy_a = 1'b0;
    auto_mode  = 1'b1;
    nc(1);
    chk("s2_pend2", 64'(pend_a), 64'd2);
    waited = 0;
    while (!((out_cnt_a - base == 3) && idle_a) && waited < 200) begin
      nc(1);
      waited++;
    end
    chk("s2_pulses", 64'(out_cnt_a - base), 64'd3);
    chk("s2_pend0",  64'(pend_a), 64'd0);
    auto_mode = 1'b0;
    nc(2);

    // Saturation on the narrow instance
    busy_b = 1'b1;
    ev_b = 1'b1;
    nc(5); ev_b = 1'b0;
    chk("s3_pend_sat", 64'(pend_b), 64'd3);
    chk("s3_ovf_set",  64'(ovf_b),  64'd1);
    clr_b = 1'b1;
    nc(1); clr_b = 1'b0;
    chk("s3_pend_clr", 64'(pend_b), 64'd0);
    chk("s3_ovf_clr",  64'(ovf_b),  64'd0);

    // Event coincident with the decrement, at 2 and at max
    ev_b = 1'b1;
    nc(2); ev_b = 1'b0;
    chk("s4_pend2", 64'(pend_b), 64'd2);
    busy_b = 1'b0; ev_b = 1'b1;
    nc(1); ev_b = 1'b0;
    chk("s4_pend_hold2", 64'(pend_b), 64'd2);
    chk("s4_out1",       64'(out_b),  64'd1);
    busy_b = 1'b1; ev_b = 1'b1;
    nc(1); ev_b = 1'b0;
    nc(2);
    chk("s4_pend3", 64'(pend_b), 64'd3);
    busy_b = 1'b0;
    nc(1); ev_b = 1'b1;
    nc(1); ev_b = 1'b0;
    chk("s4_pend_hold3", 64'(pend_b), 64'd3);
    chk("s4_ovf_clear",  64'(ovf_b),  64'd0);
    chk("s4_out2",       64'(out_b),  64'd1);
    busy_b = 1'b1;
    nc(2); busy_b = 1'b0;
    clr_b = 1'b1;
    nc(1); clr_b = 1'b0;
    nc(2);

    // clr while armed with 4 pending
    man_busy_a = 1'b1; ev_a = 1'b1;
    nc(5); ev_a = 1'b0;
    chk("s5_pend5", 64'(pend_a), 64'd5);
    man_busy_a = 1'b0;
    nc(1);
    chk("s5_out",   64'(out_a),  64'd1);
    chk("s5_pend4", 64'(pend_a), 64'd4);
    nc(1); clr_a = 1'b1;
    nc(1); clr_a = 1'b0;
    chk("s5_pend_clr", 64'(pend_a), 64'd0);
    base = out_cnt_a;
    man_busy_a = 1'b1;
    nc(3); man_busy_a = 1'b0;
    nc(2);
    chk("s5_idle", 64'(idle_a), 64'd1);
    nc(10);
    chk("s5_no_pulse", 64'(out_cnt_a - base), 64'd0);

    // Reset during DRAIN with 5 pending
    man_busy_a = 1'b1; ev_a = 1'b1;
    nc(6); ev_a = 1'b0;
    man_busy_a = 1'b0;
    nc(1);
    chk("s6_pend5", 64'(pend_a), 64'd5);
    man_busy_a = 1'b1;
    nc(2);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_pend", 64'(pend_a), 64'd0);
    chk("s6_rst_out",  64'(out_a),  64'd0);
    chk("s6_rst_idle", 64'(idle_a), 64'd1);
    nc(1);
    reset_n = 1'b1; man_busy_a = 1'b0;
    base = out_cnt_a;
    nc(10);
    chk("s6_no_pulse", 64'(out_cnt_a - base), 64'd0);
    ev_a = 1'b1;
    nc(1); ev_a = 1'b0;
    nc(1);
    chk("s6_new_out", 64'(out_a), 64'd1);
    nc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
